// File: rtl/kovacs_protocol_decoder_pkg.sv
// Shared definitions for the Kovacs protocol decoder and generator:
// phase codes, nominal indicator levels, default thresholds and widths.
package kovacs_pkg;

  localparam int unsigned SAMPLE_W = 14;
  localparam int unsigned DUR_W    = 32;
  localparam int unsigned ACC_W    = 48;

  localparam int LEVEL_ZERO = 0;
  localparam int LEVEL_RESC = 4096;
  localparam int LEVEL_RAW  = 8191;

  localparam int TH_LO_DEF = 2048;
  localparam int TH_HI_DEF = 6144;

  typedef enum logic [1:0] {
    PH_ZERO = 2'd0,
    PH_RESC = 2'd1,
    PH_RAW  = 2'd2
  } phase_t;

  typedef enum logic {
    ST_ACCEPTED = 1'b0,
    ST_PENDING  = 1'b1
  } deb_state_t;

  // Protocol order is 0 -> 2 -> 1 -> 0.
  function automatic phase_t next_phase(phase_t p);
    case (p)
      PH_ZERO: return PH_RAW;
      PH_RAW:  return PH_RESC;
      default: return PH_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/kovacs_protocol_decoder_if.sv
// Sample/statistics bundle between the ADC side and the CPU register bank.
interface kovacs_protocol_decoder_if;
  import kovacs_pkg::*;

  logic signed [SAMPLE_W-1:0] indicator_i;
  logic signed [SAMPLE_W-1:0] data_i;
  logic                       clear_i;
  logic [1:0]                 phase_o;
  logic                       dur_valid_o;
  logic [1:0]                 dur_phase_o;
  logic [DUR_W-1:0]           dur_o;
  logic [DUR_W-1:0]           dur_p0_o;
  logic [DUR_W-1:0]           dur_p1_o;
  logic [DUR_W-1:0]           dur_p2_o;
  logic signed [ACC_W-1:0]    acc_o;
  logic [DUR_W-1:0]           cycle_cnt_o;
  logic                       seq_err_o;

  modport master (
    output indicator_i, data_i, clear_i,
    input  phase_o, dur_valid_o, dur_phase_o, dur_o, dur_p0_o, dur_p1_o,
           dur_p2_o, acc_o, cycle_cnt_o, seq_err_o
  );

  modport slave (
    input  indicator_i, data_i, clear_i,
    output phase_o, dur_valid_o, dur_phase_o, dur_o, dur_p0_o, dur_p1_o,
           dur_p2_o, acc_o, cycle_cnt_o, seq_err_o
  );
endinterface

// File: rtl/kovacs_level_classifier.sv
// Registers the indicator, maps it to a phase by threshold and debounces
// the result. trans is combinational: it marks the edge on which phase
// takes the new value, with trans_old/trans_new describing the step.
module kovacs_level_classifier
  import kovacs_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 8,
  parameter int          TH_LO    = TH_LO_DEF,
  parameter int          TH_HI    = TH_HI_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] indicator,
  output phase_t                     phase,
  output logic                       trans,
  output phase_t                     trans_old,
  output phase_t                     trans_new
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE);

  logic signed [SAMPLE_W-1:0] ind_q;
  phase_t                     level, phase_q, phase_d, cand_q, cand_d;
  deb_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, run;

  // Input sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ind_q <= '0;
    else        ind_q <= indicator;
  end

  // Threshold classification; negative samples fall below TH_LO.
  always_comb begin
    if (int'(ind_q) < TH_LO)      level = PH_ZERO;
    else if (int'(ind_q) < TH_HI) level = PH_RESC;
    else                          level = PH_RAW;
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCEPTED;
      cand_q  <= PH_ZERO;
      cnt_q   <= '0;
      phase_q <= PH_ZERO;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Debounce next state: the run length of the candidate level must reach
  // DEBOUNCE before it replaces the accepted phase.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    trans   = 1'b0;
    run     = '0;
    if (level == phase_q) begin
      state_d = ST_ACCEPTED;
      cnt_d   = '0;
    end else begin
      if (state_q == ST_PENDING && level == cand_q) run = cnt_q + CNT_W'(1);
      else                                          run = CNT_W'(1);
      if (run == DEB_CNT) begin
        trans   = 1'b1;
        phase_d = level;
        state_d = ST_ACCEPTED;
        cnt_d   = '0;
      end else begin
        state_d = ST_PENDING;
        cand_d  = level;
        cnt_d   = run;
      end
    end
  end

  assign phase     = phase_q;
  assign trans_old = phase_q;
  assign trans_new = level;

endmodule

// File: rtl/kovacs_protocol_decoder.sv
// Receive-side decoder for the three-phase Kovacs drive protocol: recovers
// the phase, measures phase durations, counts cycles, flags bad order.
// Optional per-phase integration of data_i: KOVACS_DECODER_ACCUM_EN.
module kovacs_protocol_decoder
  import kovacs_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 8,
  parameter int          TH_LO    = TH_LO_DEF,
  parameter int          TH_HI    = TH_HI_DEF
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  kovacs_protocol_decoder_if.slave    bus
);

  phase_t           phase, trans_old, trans_new, dur_phase;
  logic             trans, report, primed, dur_valid, seq_err;
  logic [DUR_W-1:0] dur_cnt, dur, dur_p0, dur_p1, dur_p2, cycle_cnt;

  kovacs_level_classifier #(
    .DEBOUNCE (DEBOUNCE),
    .TH_LO    (TH_LO),
    .TH_HI    (TH_HI)
  ) u_classifier (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .indicator (bus.indicator_i),
    .phase     (phase),
    .trans     (trans),
    .trans_old (trans_old),
    .trans_new (trans_new)
  );

  // primed clear means the phase that is running started partially observed.
  assign report = trans && primed && !bus.clear_i;

  // Running length of the current phase, saturating.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)            dur_cnt <= '0;
    else if (trans)         dur_cnt <= DUR_W'(1);
    else if (dur_cnt != '1) dur_cnt <= dur_cnt + DUR_W'(1);
  end

  // Duration reports and per-phase held durations.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dur_valid <= 1'b0;
      dur_phase <= PH_ZERO;
      dur       <= '0;
      dur_p0    <= '0;
      dur_p1    <= '0;
      dur_p2    <= '0;
    end else begin
      dur_valid <= report;
      if (report) begin
        dur_phase <= trans_old;
        dur       <= dur_cnt;
        case (trans_old)
          PH_ZERO: dur_p0 <= dur_cnt;
          PH_RESC: dur_p1 <= dur_cnt;
          default: dur_p2 <= dur_cnt;
        endcase
      end
    end
  end

  // Cycle count, sequence error and partial-phase suppression; clear wins
  // over a coincident transition.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      primed    <= 1'b0;
      seq_err   <= 1'b0;
      cycle_cnt <= '0;
    end else if (bus.clear_i) begin
      primed    <= 1'b0;
      seq_err   <= 1'b0;
      cycle_cnt <= '0;
    end else if (trans) begin
      primed <= 1'b1;
      if (trans_new != next_phase(trans_old)) seq_err <= 1'b1;
      if (trans_old == PH_RESC && trans_new == PH_ZERO)
        cycle_cnt <= cycle_cnt + DUR_W'(1);
    end
  end

`ifdef KOVACS_DECODER_ACCUM_EN
  // DEBOUNCE delay stages plus the accumulator register line data_i up with
  // the cycles during which phase_o shows the phase being integrated.
  logic signed [SAMPLE_W-1:0] data_dly [DEBOUNCE];
  logic signed [ACC_W-1:0]    aligned, acc_run, acc_out;

  assign aligned = {{(ACC_W-SAMPLE_W){data_dly[DEBOUNCE-1][SAMPLE_W-1]}},
                    data_dly[DEBOUNCE-1]};

  // Data alignment delay line.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_dly <= '{default: '0};
    end else begin
      data_dly[0] <= bus.data_i;
      for (int unsigned i = 1; i < DEBOUNCE; i++) data_dly[i] <= data_dly[i-1];
    end
  end

  // Per-phase integration, frozen while the duration counter is saturated.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_run <= '0;
      acc_out <= '0;
    end else begin
      if (report)             acc_out <= acc_run;
      if (trans)              acc_run <= aligned;
      else if (dur_cnt != '1) acc_run <= acc_run + aligned;
    end
  end

  assign bus.acc_o = acc_out;
`else
  logic unused_data;
  assign unused_data = ^bus.data_i;
  assign bus.acc_o   = '0;
`endif

  assign bus.phase_o     = phase;
  assign bus.dur_valid_o = dur_valid;
  assign bus.dur_phase_o = dur_phase;
  assign bus.dur_o       = dur;
  assign bus.dur_p0_o    = dur_p0;
  assign bus.dur_p1_o    = dur_p1;
  assign bus.dur_p2_o    = dur_p2;
  assign bus.cycle_cnt_o = cycle_cnt;
  assign bus.seq_err_o   = seq_err;

endmodule
